// File: rtl/ofdm_s2p_packer.sv
// ofdm_s2p_packer: packs a serial bit stream LSB-first into NBITS-wide symbols
// and buffers them in a first-word-fall-through FIFO with valid/ready output.
module ofdm_s2p_packer #(
  parameter int NBITS = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 2,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x_in,
  input  logic             x_in_valid,
  input  logic             flush,
  input  logic             ovf_clr,
  output logic [NBITS-1:0] sym_out,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic [PTR_W:0]   fifo_level,
  output logic             ovf
);
  logic [CNT_W-1:0] cnt;
  logic [NBITS-1:0] sr, cand;
  logic [NBITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             done, full, rd, wr;
  always_comb begin
    cand = sr;
    cand[cnt] = x_in;
  end
  assign done      = x_in_valid && !flush && (cnt == CNT_W'(NBITS - 1));
  assign full      = fifo_level == (PTR_W + 1)'(DEPTH);
  assign sym_valid = fifo_level != '0;
  assign rd        = sym_valid && sym_ready;
  // a full FIFO still accepts the new word when the head pops on the same edge
  assign wr        = done && (!full || rd);
  assign sym_out   = sym_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      sr         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ovf        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (flush) begin
        cnt <= '0;
        sr  <= '0;
      end else if (x_in_valid) begin
        cnt <= done ? '0 : cnt + 1'b1;
        sr  <= done ? '0 : cand;
      end
      if (wr) begin
        mem[wr_ptr] <= cand;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + (PTR_W + 1)'(wr) - (PTR_W + 1)'(rd);
      ovf        <= (done && full && !rd) || (ovf && !ovf_clr);
    end
  end
endmodule

// File: tb/tb_ofdm_s2p_packer.sv
// tb_ofdm_s2p_packer: directed vectors for the serial-to-parallel packer.
module tb_ofdm_s2p_packer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       x_in = 1'b0;
  logic       x_in_valid = 1'b0;
  logic       flush = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       sym_ready = 1'b0;
  logic [3:0] sym_out;
  logic       sym_valid;
  logic [2:0] fifo_level;
  logic       ovf;
  int         n_chk = 0;
  int         n_pass = 0;
  ofdm_s2p_packer dut (
    .clk(clk), .reset(reset), .x_in(x_in), .x_in_valid(x_in_valid),
    .flush(flush), .ovf_clr(ovf_clr), .sym_out(sym_out), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .fifo_level(fifo_level), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b);
    x_in = b;
    x_in_valid = 1'b1;
    tick();
    x_in_valid = 1'b0;
  endtask
  task automatic send_sym(input logic [3:0] v);
    for (int i = 0; i < 4; i++) send_bit(v[i]);
  endtask
  task automatic drain(input string tag, input logic [3:0] v);
    chk({tag, "_valid"}, 32'(sym_valid), 1);
    chk(tag, 32'(sym_out), 32'(v));
    tick();
  endtask
  initial begin
    logic [3:0] stall_v [5];
    logic [3:0] fr_v [4];
    logic [3:0] ev;
    stall_v = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    fr_v = '{4'hB, 4'hC, 4'hD, 4'hE};
    #2;
    chk("rst_valid", 32'(sym_valid), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_out", 32'(sym_out), 0);
    chk("rst_ovf", 32'(ovf), 0);
    tick();
    reset = 1'b1;
    tick();
    // basic pack: bits 0,1,1,0 -> 4'b0110, popped on the following edge
    sym_ready = 1'b1;
    send_bit(0); send_bit(1); send_bit(1);
    chk("pack_early", 32'(sym_valid), 0);
    send_bit(0);
    chk("pack_valid", 32'(sym_valid), 1);
    chk("pack_out", 32'(sym_out), 32'h6);
    tick();
    chk("pack_onecyc", 32'(sym_valid), 0);
    // stall fill: fifth symbol dropped
    sym_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send_sym(stall_v[k]);
      chk("stall_level", 32'(fifo_level), (k < 4) ? k + 1 : 4);
      chk("stall_ovf", 32'(ovf), (k < 4) ? 0 : 1);
    end
    chk("stall_head", 32'(sym_out), 32'h1);
    sym_ready = 1'b1;
    for (int k = 0; k < 4; k++) drain("stall_drain", stall_v[k]);
    chk("stall_empty", 32'(sym_valid), 0);
    chk("stall_lvl0", 32'(fifo_level), 0);
    sym_ready = 1'b0;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_ovf", 32'(ovf), 0);
    // full FIFO with write and pop on the same edge
    send_sym(4'hA); send_sym(4'hB); send_sym(4'hC); send_sym(4'hD);
    chk("fr_full", 32'(fifo_level), 4);
    ev = 4'hE;
    for (int i = 0; i < 3; i++) send_bit(ev[i]);
    sym_ready = 1'b1;
    send_bit(ev[3]);
    chk("fr_ovf", 32'(ovf), 0);
    chk("fr_level", 32'(fifo_level), 4);
    for (int k = 0; k < 4; k++) drain("fr_drain", fr_v[k]);
    chk("fr_empty", 32'(sym_valid), 0);
    // flush mid-symbol, flush beats a simultaneous valid bit
    sym_ready = 1'b0;
    send_bit(1); send_bit(1);
    x_in = 1'b1; x_in_valid = 1'b1; flush = 1'b1;
    tick();
    x_in_valid = 1'b0; flush = 1'b0;
    send_bit(0); send_bit(1); send_bit(0);
    chk("fl_none", 32'(fifo_level), 0);
    send_bit(1);
    chk("fl_level", 32'(fifo_level), 1);
    chk("fl_out", 32'(sym_out), 32'hA);
    sym_ready = 1'b1;
    tick();
    sym_ready = 1'b0;
    chk("fl_empty", 32'(fifo_level), 0);
    // gapped input: 1,0,0,1 with idle cycles -> 0x9
    send_bit(1); tick(); send_bit(0); tick(); send_bit(0); tick(); tick(); send_bit(1);
    chk("gap_out", 32'(sym_out), 32'h9);
    chk("gap_level", 32'(fifo_level), 1);
    // async reset mid-symbol with data buffered
    send_bit(1); send_bit(1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid", 32'(sym_valid), 0);
    chk("ar_level", 32'(fifo_level), 0);
    chk("ar_out", 32'(sym_out), 0);
    tick();
    reset = 1'b1;
    tick();
    send_bit(1); send_bit(0); send_bit(0);
    chk("ar_restart_none", 32'(sym_valid), 0);
    send_bit(0);
    chk("ar_restart", 32'(sym_out), 32'h1);
    chk("ar_restart_lvl", 32'(fifo_level), 1);
    // sticky overflow flag
    send_sym(4'h2); send_sym(4'h3); send_sym(4'h4);
    chk("st_pre", 32'(ovf), 0);
    send_sym(4'h5);
    chk("st_set", 32'(ovf), 1);
    for (int i = 0; i < 10; i++) tick();
    chk("st_hold", 32'(ovf), 1);
    chk("st_head", 32'(sym_out), 32'h1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("st_clr", 32'(ovf), 0);
    ev = 4'h7;
    for (int i = 0; i < 3; i++) send_bit(ev[i]);
    ovf_clr = 1'b1;
    send_bit(ev[3]);
    ovf_clr = 1'b0;
    chk("st_setwins", 32'(ovf), 1);
    chk("st_level", 32'(fifo_level), 4);
    sym_ready = 1'b1;
    drain("st_drain", 4'h1); drain("st_drain", 4'h2);
    drain("st_drain", 4'h3); drain("st_drain", 4'h4);
    chk("st_empty", 32'(sym_valid), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ofdm_s2p_packer.md
Name: ofdm_s2p_packer

Overview:
Upstream feeder for the OFDM top. Accepts a serial bit stream (one bit per cycle when qualified) and packs it LSB-first into NBITS-wide symbols. Symbols are buffered in a small first-word-fall-through FIFO and presented on a valid/ready interface to the OFDM symbol mapper. It also provides a flush for frame boundaries and a sticky overflow flag.

Parameters:
NBITS, 4, bits per packed symbol (matches the 4-bit OFDM symbol width)
DEPTH, 4, FIFO depth in symbols; power of two, at least 2
CNT_W, 2, width of the bit counter; equals log2(NBITS)
PTR_W, 2, width of the FIFO pointers; equals log2(DEPTH)

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset; 0 resets all state immediately, release is synchronous to clk
x_in  in  1  serial data bit
x_in_valid  in  1  qualifies x_in for this cycle
flush  in  1  discard the partially packed symbol; FIFO contents are kept
ovf_clr  in  1  clears the sticky overflow flag
sym_out  out  NBITS  FIFO head symbol
sym_valid  out  1  FIFO not empty
sym_ready  in  1  consumer accepts sym_out when sym_valid and sym_ready are both 1
fifo_level  out  PTR_W+1  number of symbols held, 0..DEPTH
ovf  out  1  sticky flag: a completed symbol was dropped

Behaviour:
- Reset (reset = 0): bit counter = 0, shift register = 0, FIFO empty, pointers = 0, sym_out = 0, sym_valid = 0, fifo_level = 0, ovf = 0. Reset applies mid-symbol and mid-burst; all partial and buffered data is lost.
- Packing:
  - On each edge with x_in_valid = 1, x_in is written to bit position cnt of the shift register and cnt increments.
  - The first bit received is the LSB of the symbol.
  - Cycles with x_in_valid = 0 hold all packing state; gaps are allowed anywhere in a symbol.
- Symbol completion: at the edge where x_in_valid = 1 and cnt = NBITS-1:
  - the completed word (the NBITS-1 held bits plus the current bit in the MSB position) is the write candidate;
  - cnt wraps to 0.
- FIFO write: the candidate is written if the FIFO is not full, or if it is full and a read occurs on the same edge. The write pointer wraps modulo DEPTH.
- Overflow: if the FIFO is full with no read on that edge, the candidate is dropped, ovf is set to 1 and the FIFO is unchanged.
- Read: when sym_valid = 1 and sym_ready = 1, the head entry is popped at the edge and the read pointer wraps modulo DEPTH. sym_ready while empty has no effect.
- Output timing:
  - sym_out is the registered FIFO head (first-word fall-through).
  - A symbol completed at edge N appears on sym_out with sym_valid = 1 immediately after edge N, provided the FIFO was empty. This is zero extra cycles of latency.
- Simultaneous read and write:
  - When empty, only a write can occur, so level goes 0 -> 1.
  - When full, level stays at DEPTH and order is preserved: the new word goes to the tail and the head advances.
  - When neither empty nor full, level is unchanged.
- fifo_level: writes minus reads, kept in the range 0..DEPTH and updated on the same edge as the pointers.
- flush:
  - Sets cnt to 0 and the shift register to 0 at the edge. The FIFO is unaffected.
  - flush has priority over a simultaneous x_in_valid: that bit is discarded and no symbol completes on that edge.
- ovf_clr: clears ovf at the edge. If an overflow occurs on the same edge, setting wins and ovf stays 1.
- sym_out may change only when sym_valid is 0 or after a pop. The consumer sees a stable head while it stalls.

Test Plan:
- Basic pack: release reset, send bits 0,1,1,0 with x_in_valid = 1 on consecutive cycles and sym_ready = 1 -> after the 4th edge sym_out = 4'b0110 and sym_valid = 1 for exactly one cycle.
- Stall fill: sym_ready = 0, send 20 bits forming 0x1,0x2,0x3,0x4,0x5 -> fifo_level counts 1..4; the fifth symbol is dropped and ovf = 1. Then sym_ready = 1 -> outputs are 0x1,0x2,0x3,0x4 in order, then sym_valid = 0.
- Full read and write: with the FIFO full (0xA,0xB,0xC,0xD), complete 0xE on the same edge as a pop -> ovf stays 0, fifo_level = 4, and the drain order is 0xB,0xC,0xD,0xE.
- Flush mid-symbol: send 1,1 then assert flush, then send 0,1,0,1 -> the single output is 4'b1010 and no symbol forms from the flushed bits.
- Gapped input and reset: send bits with x_in_valid toggling every cycle -> the packed values are correct. Then pull reset = 0 after 2 bits of a new symbol -> all outputs return to 0 asynchronously, before the next clk edge. After release, packing restarts at bit 0.
- Sticky flag: cause an overflow, hold ovf_clr = 0 for 10 cycles -> ovf stays 1. Assert ovf_clr with no overflow -> ovf = 0 on the next edge. Assert ovf_clr on the same edge as an overflow -> ovf = 1.
